scoreboard_regfile: RTL and testbench
=====================================

// Module: scoreboard_regfile
// PURPOSE
//  Parametrised register file for the pipelined CPU: NUM_RD combinational read ports,
//  one write-back port, optional write-to-read bypass, optional hardwired-zero register 0.
//  A per-register pending scoreboard tracks destinations issued from ID but not yet
//  written back. It produces the ID-stage stall for RAW and (optionally) WAW hazards.
//  Sits in ID; the write port is driven from the WB stage.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; depth = 2**ADDR_W
//  NUM_RD    2   number of read ports (>=1)
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
//  ZERO_REG  1   1: register 0 reads 0, is never written, is never pending
//  WAW_STALL 1   1: also stall when the issuing destination is already pending
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active low
//  rd_addr    in   NUM_RD*ADDR_W  read addresses; port i = [i*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W  read data; port i = [i*DATA_W +: DATA_W]
//  wr_en      in   1              write-back strobe
//  wr_addr    in   ADDR_W         write-back address
//  wr_data    in   DATA_W         write-back data
//  iss_valid  in   1              an instruction is attempting to leave ID this cycle
//  iss_uses   in   NUM_RD         bit i: the instruction reads rd_addr port i
//  iss_wr     in   1              the instruction writes a destination register
//  iss_dest   in   ADDR_W         destination register of the issuing instruction
//  stall      out  1              hold ID/IF; the issue is not accepted this cycle
//  pending    out  2**ADDR_W      scoreboard bit vector, bit r = register r pending
//  pend_cnt   out  ADDR_W+1       population count of pending
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - All registers are cleared to 0 and all pending bits to 0.
//   - Reset overrides wr_en and issue in that cycle.
//   - After reset: stall=0, pend_cnt=0, rd_data=0.
//  Read (combinational, zero latency):
//   - rd_data[i] = 0 when ZERO_REG and rd_addr[i]==0.
//   - Otherwise, when BYPASS and wr_en and wr_addr==rd_addr[i], rd_data[i] = wr_data.
//   - Otherwise rd_data[i] = regs[rd_addr[i]].
//  Write: at posedge with wr_en=1, regs[wr_addr] <= wr_data. The write is ignored when
//   ZERO_REG and wr_addr==0. With BYPASS=0, the new value is readable from the next cycle.
//  Scoreboard clear: wr_en clears pending[wr_addr] at the posedge.
//  Hazard terms:
//   - raw_i = iss_uses[i] & pending[rd_addr[i]] & ~(BYPASS & wr_en & wr_addr==rd_addr[i]).
//   - waw   = WAW_STALL & iss_wr & pending[iss_dest] & ~(wr_en & wr_addr==iss_dest).
//   - stall = iss_valid & (OR of raw_i | waw). Purely combinational.
//  Accepted issue: iss_valid & ~stall & iss_wr & ~(ZERO_REG & iss_dest==0) sets
//   pending[iss_dest] at the posedge.
//  Simultaneous set and clear of the same register: set wins, so the register stays pending.
//  pend_cnt is combinational from the registered pending vector. Maximum
//   2**ADDR_W - ZERO_REG; no wrap.
//  Writes to a non-pending register are legal: data is updated and the scoreboard is unchanged.
//  iss_* inputs are don't-care when iss_valid=0. No state changes when iss_valid=0,
//   except the wr_en effects.
// TESTING
//  T1 reset: write r5=0x1234, then pulse rst_n=0 for one cycle
//   -> r5 reads 0, pending=0, pend_cnt=0, stall=0.
//  T2 bypass: wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, rd_addr port0=3, same cycle
//   -> rd_data0=0xDEADBEEF (BYPASS=1); with BYPASS=0 -> old value, new value next cycle.
//  T3 RAW stall: issue iss_dest=7; next cycle iss_uses[1]=1, rd_addr1=7 -> stall=1
//   until the cycle wr_en,wr_addr=7, where stall=0 and rd_data1=wr_data.
//  T4 zero reg: write r0=0xFFFF, issue iss_dest=0 -> rd r0=0, pending[0]=0, stall never asserted.
//  T5 set/clear collision: r9 pending; same cycle wr_en wr_addr=9 and accepted issue dest=9
//   -> pending[9]=1 after the edge, pend_cnt unchanged.
//  T6 WAW + reset mid-flight: r4 pending, issue dest=4 -> stall=1 (WAW_STALL=1);
//   assert rst_n=0 -> stall=0 and pending cleared next cycle.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// Register file with combinational read ports, one write-back port and a per-register
// pending scoreboard that raises the ID-stage stall on RAW and WAW hazards.
module scoreboard_regfile #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int WAW_STALL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_valid,
  input  logic [NUM_RD-1:0]          iss_uses,
  input  logic                       iss_wr,
  input  logic [ADDR_W-1:0]          iss_dest,
  output logic                       stall,
  output logic [(1<<ADDR_W)-1:0]     pending,
  output logic [ADDR_W:0]            pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);
  localparam bit HAS_WAW  = (WAW_STALL != 0);

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [NUM_RD-1:0] raw;
  logic              waw;
  logic              wr_ok;
  logic              iss_accept;

  assign wr_ok = wr_en && !(HAS_ZERO && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              byp_hit;
      assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign byp_hit = HAS_BYP && wr_en && (wr_addr == addr);

      always_comb begin
        rd_data[gi*DATA_W +: DATA_W] = regs_reg[addr];
        if (HAS_ZERO && (addr == '0)) begin
          rd_data[gi*DATA_W +: DATA_W] = '0;
        end else if (byp_hit) begin
          rd_data[gi*DATA_W +: DATA_W] = wr_data;
        end
      end

      // A forwarded write-back satisfies the dependency in the same cycle.
      assign raw[gi] = iss_uses[gi] && pending_reg[addr] && !byp_hit;
    end
  endgenerate

  assign waw   = HAS_WAW && iss_wr && pending_reg[iss_dest]
                 && !(wr_en && (wr_addr == iss_dest));
  assign stall = iss_valid && ((|raw) || waw);

  assign iss_accept = iss_valid && !stall && iss_wr
                      && !(HAS_ZERO && (iss_dest == '0));

  // Set is applied after clear so a same-register collision stays pending.
  always_comb begin
    pending_next = pending_reg;
    if (wr_en) begin
      pending_next[wr_addr] = 1'b0;
    end
    if (iss_accept) begin
      pending_next[iss_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign pending = pending_reg;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt = pend_cnt + (ADDR_W+1)'(pending_reg[i]);
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile with default parameters (bypass, zero reg, WAW stall).
module tb_scoreboard_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_valid;
  logic [NUM_RD-1:0]        iss_uses;
  logic                     iss_wr;
  logic [ADDR_W-1:0]        iss_dest;
  logic                     stall;
  logic [(1<<ADDR_W)-1:0]   pending;
  logic [ADDR_W:0]          pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  scoreboard_regfile dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_uses(iss_uses), .iss_wr(iss_wr), .iss_dest(iss_dest),
    .stall(stall), .pending(pending), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_uses = '0; iss_wr = 1'b0; iss_dest = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_cnt", 64'(pend_cnt), 64'd0);
    check("reset_rd", 64'(rd_data), 64'd0);

    // T1: write r5, then reset with a write and an issue attempted in the same cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    step();
    wr_en = 1'b0; set_rd(5'd5, 5'd0);
    #1;
    check("t1_r5_written", 64'(rd_data[31:0]), 64'h1234);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h99;
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 5'd6;
    step();
    rst_n = 1'b1; wr_en = 1'b0; iss_valid = 1'b0; iss_wr = 1'b0;
    #1;
    check("t1_r5_cleared", 64'(rd_data[31:0]), 64'h0);
    check("t1_pending", 64'(pending), 64'h0);
    check("t1_cnt", 64'(pend_cnt), 64'd0);
    check("t1_stall", 64'(stall), 64'd0);

    // T2: same-cycle bypass, then stored value
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; set_rd(5'd3, 5'd0);
    #1;
    check("t2_bypass", 64'(rd_data[31:0]), 64'hDEADBEEF);
    step();
    wr_en = 1'b0;
    #1;
    check("t2_stored", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // T3: RAW stall on port 1 until write-back of r7
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 5'd7; iss_uses = 2'b00;
    #1;
    check("t3_issue_ok", 64'(stall), 64'd0);
    step();
    iss_wr = 1'b0; iss_uses = 2'b10; set_rd(5'd7, 5'd3);
    #1;
    check("t3_unused_port", 64'(stall), 64'd0);
    set_rd(5'd3, 5'd7);
    #1;
    check("t3_raw_stall", 64'(stall), 64'd1);
    check("t3_pending", 64'(pending), 64'h80);
    check("t3_cnt", 64'(pend_cnt), 64'd1);
    step();
    #1;
    check("t3_still_stall", 64'(stall), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE0007;
    #1;
    check("t3_wb_release", 64'(stall), 64'd0);
    check("t3_wb_fwd", 64'(rd_data[63:32]), 64'hCAFE0007);
    step();
    wr_en = 1'b0; iss_valid = 1'b0; iss_uses = 2'b00;
    #1;
    check("t3_cleared", 64'(pending), 64'h0);

    // T4: register 0 is hardwired and never pending
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF; set_rd(5'd0, 5'd0);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 5'd0;
    #1;
    check("t4_rd0_byp", 64'(rd_data[31:0]), 64'h0);
    check("t4_stall", 64'(stall), 64'd0);
    step();
    wr_en = 1'b0; iss_uses = 2'b01;
    #1;
    check("t4_rd0", 64'(rd_data[31:0]), 64'h0);
    check("t4_pending", 64'(pending), 64'h0);
    check("t4_stall2", 64'(stall), 64'd0);

    // T5: set/clear collision on r9 keeps it pending
    iss_uses = 2'b00; iss_dest = 5'd9;
    step();
    iss_dest = 5'd12;
    step();
    #1;
    check("t5_pre_cnt", 64'(pend_cnt), 64'd2);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; iss_dest = 5'd9;
    #1;
    check("t5_no_waw", 64'(stall), 64'd0);
    step();
    wr_en = 1'b0; iss_valid = 1'b0; set_rd(5'd9, 5'd12);
    #1;
    check("t5_pending", 64'(pending), 64'h1200);
    check("t5_cnt", 64'(pend_cnt), 64'd2);
    check("t5_r9", 64'(rd_data[31:0]), 64'h55);

    // T6: WAW stall, then reset mid-flight
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 5'd4;
    step();
    #1;
    check("t6_cnt3", 64'(pend_cnt), 64'd3);
    check("t6_waw", 64'(stall), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("t6_rst_stall", 64'(stall), 64'd0);
    check("t6_rst_pending", 64'(pending), 64'h0);
    step();
    iss_valid = 1'b0;
    #1;
    check("t6_reissue", 64'(pending), 64'h10);
    check("t6_reissue_cnt", 64'(pend_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
